// File: rtl/pulse_debouncer.sv
// Pushbutton debouncer: 2-flop synchronizer, polarity normalization, and a
// four-state FSM that emits one registered enable strobe per accepted press.
module pulse_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       enable_pulse,
  output logic       btn_level,
  output logic [1:0] state_dbg
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  // Pin level when the button is released.
  localparam logic           REL_LVL  = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  logic          sync1, sync2;
  logic          pressed;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pulse_n, level_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ REL_LVL;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      enable_pulse <= 1'b0;
      btn_level    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      enable_pulse <= pulse_n;
      btn_level    <= level_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are computed from the upcoming state so they register alongside it.
  always_comb begin
    pulse_n   = (state == PRESS_WAIT) && (state_n == PRESSED);
    level_n   = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    state_dbg = state;
  end

endmodule

// File: tb/tb_pulse_debouncer.sv
// Directed bench for pulse_debouncer (N=4, active-low button) with an
// expectation queue and a downstream 2-bit accumulator register.
module tb_pulse_debouncer;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       enable_pulse;
  logic       btn_level;
  logic [1:0] state_dbg;
  logic       acc_clr;
  logic [1:0] acc;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  typedef struct {
    string      tag;
    logic       pulse;
    logic       level;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  pulse_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .enable_pulse(enable_pulse),
    .btn_level   (btn_level),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (acc_clr) acc <= '0;
    else if (enable_pulse) acc <= acc + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic ep, input logic el,
                      input logic [1:0] es, input string tag);
    exp_t e;
    reset   = r;
    btn_raw = b;
    e.tag = tag; e.pulse = ep; e.level = el; e.st = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pulse"}, 32'(enable_pulse), 32'(e.pulse));
    chk({e.tag, ".level"}, 32'(btn_level), 32'(e.level));
    chk({e.tag, ".state"}, 32'(state_dbg), 32'(e.st));
    if (enable_pulse === 1'b1) pulses++;
  endtask

  // Edge k counts from the first edge that samples the pressed pin.
  function automatic logic [1:0] press_st(int k);
    return (k < 3) ? 2'b00 : (k < 7) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rel_st(int k);
    return (k < 3) ? 2'b10 : (k < 7) ? 2'b11 : 2'b00;
  endfunction

  task automatic press(input int n, input string tag);
    for (int k = 1; k <= n; k++)
      step(1'b1, 1'b0, k == 7, k >= 7, press_st(k), tag);
  endtask

  task automatic release_btn(input int n, input string tag);
    for (int k = 1; k <= n; k++)
      step(1'b1, 1'b1, 1'b0, k < 7, rel_st(k), tag);
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b0;
    btn_raw = 1'b1;
    acc_clr = 1'b1;

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, "reset");
    acc_clr = 1'b0;

    press(12, "press12");
    release_btn(10, "rel12");

    // Bounce pattern pressed,pressed,released repeating; pressed runs never reach N.
    for (int e = 1; e <= 34; e++) begin
      int  i;
      logic exp_pw;
      i      = e - 3;
      exp_pw = (e >= 3) && (i < 30) && ((i % 3) != 2);
      step(1'b1, ((e - 1) < 30 && ((e - 1) % 3) != 2) ? 1'b0 : 1'b1,
           1'b0, 1'b0, {1'b0, exp_pw}, "bounce");
    end

    pulses = 0;
    press(10, "hold");
    for (int g = 1; g <= 30; g++)
      step(1'b1, (g <= 2) ? 1'b1 : 1'b0, 1'b0, 1'b1,
           (g == 3 || g == 4) ? 2'b11 : 2'b10, "glitch");
    chk("glitch.pulse_count", 32'(pulses), 32'd1);
    release_btn(10, "rel_glitch");

    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0, press_st(k), "pre_rst");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "mid_rst");
    pulses = 0;
    press(10, "post_rst");
    chk("post_rst.pulse_count", 32'(pulses), 32'd1);
    release_btn(10, "rel_rst");

    acc_clr = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, "acc_clr");
    acc_clr = 1'b0;
    chk("acc.cleared", 32'(acc), 32'd0);
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      press(8, "acc_press");
      release_btn(8, "acc_rel");
    end
    chk("acc.pulse_count", 32'(pulses), 32'd3);
    chk("acc.value", 32'(acc), 32'd3);
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
